// File: rtl/riscv_alu_pkg.sv
// rtl/riscv_alu_pkg.sv - shared ALU opcodes and multiply sequencer state encoding
package riscv_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_ORI  = 4'b0010;
  localparam logic [3:0] ALU_SLLI = 4'b0011;
  localparam logic [3:0] ALU_SRLI = 4'b0100;
  localparam logic [3:0] ALU_LUI  = 4'b0101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADD  = 3'd1,
    ST_SHL  = 3'd2,
    ST_SHR  = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/riscv_alu.sv
// rtl/riscv_alu.sv - combinational RV32 ALU shared by the multiply sequencer
module riscv_alu
  import riscv_alu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o,
  output logic        Zero_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_ORI:  result_o = a_i | b_i;
      ALU_SLLI: result_o = a_i << b_i[4:0];
      ALU_SRLI: result_o = a_i >> b_i[4:0];
      // LUI operand arrives already positioned in the upper bits
      ALU_LUI:  result_o = b_i;
      default:  result_o = '0;
    endcase
  end

  assign Zero_o = (result_o == 32'd0);

endmodule

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - shift-and-add 32x32 multiplier, one ALU op per cycle
module mul_sequencer
  import riscv_alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] multiplicand_i,
  input  logic [31:0] multiplier_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  seq_state_t  state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_res;
  logic        alu_zero;

  riscv_alu u_alu (
    .op_i     (alu_op),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_res),
    .Zero_o   (alu_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_ADD;
      ST_ADD:  state_d = ST_SHL;
      ST_SHL:  state_d = ST_SHR;
      // Zero_o here reflects the shifted multiplier: no set bits remain
      ST_SHR:  state_d = (alu_zero || cnt_q == 5'd31) ? ST_DONE : ST_ADD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alu_op = ALU_ADD;
    alu_a  = acc_q;
    alu_b  = '0;
    case (state_q)
      ST_ADD: alu_b = mcand_q;
      ST_SHL: begin
        alu_op = ALU_SLLI;
        alu_a  = mcand_q;
        alu_b  = 32'd1;
      end
      ST_SHR: begin
        alu_op = ALU_SRLI;
        alu_a  = mplier_q;
        alu_b  = 32'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: if (start_i) begin
        acc_d    = '0;
        mcand_d  = multiplicand_i;
        mplier_d = multiplier_i;
        cnt_d    = '0;
      end
      ST_ADD: if (mplier_q[0]) acc_d = alu_res;
      ST_SHL: mcand_d = alu_res;
      ST_SHR: begin
        mplier_d = alu_res;
        cnt_d    = cnt_q + 5'd1;
      end
      default: ;
    endcase
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = (state_q == ST_DONE);
  assign product_o = acc_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// tb/tb_mul_sequencer.sv - directed and random checks of mul_sequencer against an arithmetic model
module tb_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] multiplicand_i = '0;
  logic [31:0] multiplier_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [31:0] product_o;

  int n_checks = 0;
  int n_fail = 0;

  mul_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .product_o      (product_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ref_iters(input logic [31:0] b);
    int n;
    n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = {32'd0, a} * {32'd0, b};
    return full[31:0];
  endfunction

  // intrude: 1 = second start at E4 with new operands, 2 = start held during DONE
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int intrude);
    int n;
    logic [31:0] exp;
    n   = ref_iters(b);
    exp = ref_product(a, b);
    @(negedge clk);
    start_i        = 1'b1;
    multiplicand_i = a;
    multiplier_i   = b;
    @(posedge clk);
    @(negedge clk);
    start_i        = 1'b0;
    multiplicand_i = $urandom;
    multiplier_i   = $urandom;
    check("busy_after_accept", {31'd0, busy_o}, 32'd1);
    for (int k = 1; k <= 3 * n + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("done_window", {31'd0, done_o}, {31'd0, (k == 3 * n)});
      check("busy_window", {31'd0, busy_o}, {31'd0, (k <= 3 * n)});
      if (k >= 3 * n) check("product", product_o, exp);
      if (intrude == 1 && k == 3) begin
        start_i = 1'b1; multiplicand_i = 32'd2; multiplier_i = 32'd2;
      end
      if (intrude == 1 && k == 4) start_i = 1'b0;
      if (intrude == 2 && k == 3 * n) start_i = 1'b1;
      if (k == 3 * n + 1) start_i = 1'b0;
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_after_done", {30'd0, busy_o, done_o}, 32'd0);
      check("product_held", product_o, exp);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    #1;
    check("reset_busy", {31'd0, busy_o}, 32'd0);
    check("reset_done", {31'd0, done_o}, 32'd0);
    check("reset_product", product_o, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy_o}, 32'd0);

    do_mul(32'd3, 32'd5, 0);
    do_mul(32'h1234, 32'd0, 0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_mul(32'h0001_0000, 32'h0001_0000, 0);
    do_mul(32'd7, 32'd6, 1);
    do_mul(32'hDEAD_BEEF, 32'h0000_0013, 2);

    // reset mid-operation: outputs clear without a clock edge, no done pulse
    @(negedge clk);
    start_i = 1'b1; multiplicand_i = 32'd9; multiplier_i = 32'hFF;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_done", {31'd0, done_o}, 32'd0);
    check("abort_product", product_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) begin
      @(negedge clk);
      check("no_done_after_abort", {30'd0, busy_o, done_o}, 32'd0);
    end
    do_mul(32'd9, 32'd2, 0);

    for (int r = 0; r < 8; r++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      do_mul(ra, rb, r % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter: none; all widths fixed at 32 bits (RV32 datapath).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  request pulse; sampled only in IDLE.
REQ-005 multiplicand_i  input  32  operand A, latched when start_i is accepted.
REQ-006 multiplier_i  input  32  operand B, latched when start_i is accepted.
REQ-007 busy_o  output  1  high in every state except IDLE.
REQ-008 done_o  output  1  one-cycle completion strobe.
REQ-009 product_o  output  32  low 32 bits of A*B; valid while done_o is high, held until the next accepted start.

Function
REQ-010 The block SHALL compute the product by shift-and-add, issuing exactly one operation per cycle to a single internal ALU instance.
REQ-011 States SHALL be IDLE, ADD, SHL, SHR, DONE.
REQ-012 IDLE: on start_i=1, latch acc=0, mcand=multiplicand_i, mplier=multiplier_i, cnt=0, and go to ADD; otherwise remain in IDLE.
REQ-013 ADD: drive ALU op ADD (4'b0000), A=acc, B=mcand; load acc from the ALU result only if mplier[0]=1; go to SHL.
REQ-014 SHL: drive op SLLI (4'b0011), A=mcand, B=1; load mcand from the result; go to SHR.
REQ-015 SHR: drive op SRLI (4'b0100), A=mplier, B=1; load mplier from the result and increment cnt (5 bits).
REQ-016 In SHR, go to DONE if ALU Zero_o=1 or cnt (pre-increment) = 31; otherwise go to ADD.
REQ-017 DONE: done_o=1 and product_o=acc; unconditionally go to IDLE.
REQ-018 Let N be the iteration count: max(1, index of the highest set bit of the multiplier + 1), at most 32.
REQ-019 With the accepting edge as E0, DONE SHALL be entered at edge E(3N), and done_o SHALL be high only between E(3N) and E(3N+1).
REQ-020 Arithmetic SHALL wrap modulo 2^32, and the result SHALL be identical for signed and unsigned interpretations of the operands.
REQ-021 start_i asserted in any state other than IDLE SHALL be ignored, including in DONE; it SHALL NOT be queued.
REQ-022 Operand input changes after acceptance SHALL NOT affect the result.
REQ-023 In IDLE and DONE, the ALU operation SHALL be ADD with A=acc and B=0 so that no X appears on the ALU inputs.

Reset
REQ-024 reset=1 SHALL force state=IDLE, busy_o=0, done_o=0, product_o=0, and acc=mcand=mplier=0 and cnt=0, immediately and without waiting for clk.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done_o pulse; the first start_i accepted after reset release SHALL behave as in REQ-012.

Structure
REQ-026 The ALU opcode constants (ADD, LUI, ORI, SLLI, SRLI, SUB) and the sequencer state encoding SHALL reside in the shared package riscv_alu_pkg.
REQ-027 The block SHALL contain exactly one sub-module, the existing ALU, instantiated once; it SHALL NOT use a multiplier operator.
REQ-028 Outputs busy_o, done_o and product_o SHALL be derived from registered state and registered acc only.

Verification
REQ-029 A=3, B=5, start pulse at E0 -> N=3; done_o high only between E9 and E10; product_o=15; busy_o high from E0 to E9.
REQ-030 A=0x1234, B=0 -> N=1; done_o between E3 and E4; product_o=0.
REQ-031 A=0xFFFFFFFF, B=0xFFFFFFFF -> N=32; done_o between E96 and E97; product_o=0x00000001.
REQ-032 A=0x00010000, B=0x00010000 -> product_o=0 (wrap); N=17; done_o between E51 and E52.
REQ-033 A=7, B=6 accepted, then at E4 start_i=1 with A=2, B=2 and the operand inputs changed -> second start ignored; single done_o with product_o=42; busy_o stays high until done.
REQ-034 A=9, B=0xFF accepted, reset pulsed at E10 -> busy_o=0 and product_o=0 immediately, no done_o; then start with A=9, B=2 -> product_o=18 at E6.
